// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage in front of the integer register file.
// Owns the single register-file write port and merges two producers:
//   - ex: single-cycle execute results, accepted directly
//   - ls: long-latency load/mul-div results, buffered in an LS_DEPTH FIFO
// Also keeps the pending-write scoreboard for long-latency destinations.
//
// Ports:
//   clock, reset              clock; synchronous active-high reset
//   exValid/exRd/exData       execute result in; exReady out (FIFO not full)
//   lsValid/lsRd/lsData       long-latency result in; lsReady out (FIFO not full)
//   issueValid/issueRd        long-latency op issued; sets busy[issueRd]
//   wen/wAddr/wData           registered register-file write port
//   busy                      scoreboard, bit i = long-latency write to xi pending
module wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int LS_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exValid,
  input  logic [4:0]      exRd,
  input  logic [XLEN-1:0] exData,
  output logic            exReady,
  input  logic            lsValid,
  input  logic [4:0]      lsRd,
  input  logic [XLEN-1:0] lsData,
  output logic            lsReady,
  input  logic            issueValid,
  input  logic [4:0]      issueRd,
  output logic            wen,
  output logic [4:0]      wAddr,
  output logic [XLEN-1:0] wData,
  output logic [31:0]     busy
);

  localparam int PW = (LS_DEPTH > 1) ? $clog2(LS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LS_DEPTH);

  // FIFO storage; pointers wrap naturally since LS_DEPTH is a power of two
  logic [LS_DEPTH-1:0][4:0]      fifo_rd_q;
  logic [LS_DEPTH-1:0][XLEN-1:0] fifo_data_q;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;

  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            full, empty;
  logic            push, pop, sel_ex;
  logic [4:0]      head_rd, sel_rd;
  logic [XLEN-1:0] head_data, sel_data;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Ready depends only on registered occupancy, so a same-cycle pop from a
  // full FIFO does not open a slot until the next cycle.
  assign lsReady = !full;
  assign exReady = !full;

  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Full FIFO must drain first; otherwise ex has priority over a waiting head.
  assign sel_ex = !full && exValid;
  assign pop    = full || (!exValid && !empty);
  assign push   = lsValid && !full;

  assign sel_rd   = pop ? head_rd   : exRd;
  assign sel_data = pop ? head_data : exData;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A consumed rd==0 result still leaves the port idle; address/data hold.
  always_comb begin
    wen_d   = (pop || sel_ex) && (sel_rd != 5'd0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wen_d) begin
      waddr_d = sel_rd;
      wdata_d = sel_data;
    end
  end

  // Clear on ls retire, then set on issue so a re-issue to the same rd wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && head_rd != 5'd0)
      busy_d[head_rd] = 1'b0;
    if (issueValid && issueRd != 5'd0)
      busy_d[issueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: entries are only visible through count/pointers.
  for (genvar i = 0; i < LS_DEPTH; i++) begin : g_slot
    always_ff @(posedge clock) begin
      if (push && wr_ptr_q == PW'(i)) begin
        fifo_rd_q[i]   <= lsRd;
        fifo_data_q[i] <= lsData;
      end
    end
  end

  assign wen   = wen_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;
  assign busy  = busy_q;

endmodule
